// File: rtl/lsu_pkg.sv
// Shared definitions for the dmem load/store unit: FSM state encoding,
// byte-lane select constants and the request address check.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RMW   = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_t;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    // A request is rejected when a word access is not word aligned or when the
    // full 30-bit word index falls outside the implemented memory.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input logic        is_byte,
                                      input int unsigned mem_words);
        logic [31:0] idx;
        idx = {2'b00, addr[31:2]};
        return ((!is_byte) && (addr[1:0] != 2'b00)) || (idx >= mem_words);
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane helper for the LSU: extracts one little-endian byte
// from a word (sign- or zero-extended) and merges a byte into a word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    input  logic [7:0]  byte_in,
    output logic [31:0] ext_word,
    output logic [31:0] merged_word
);

    logic [7:0] sel_byte;

    // Pick the addressed lane, extend it, and build the read-modify-write word.
    always_comb begin
        sel_byte    = word[7:0];
        merged_word = word;
        case (lane)
            LANE0: begin
                sel_byte          = word[7:0];
                merged_word[7:0]  = byte_in;
            end
            LANE1: begin
                sel_byte          = word[15:8];
                merged_word[15:8] = byte_in;
            end
            LANE2: begin
                sel_byte           = word[23:16];
                merged_word[23:16] = byte_in;
            end
            LANE3: begin
                sel_byte           = word[31:24];
                merged_word[31:24] = byte_in;
            end
            default: begin
                sel_byte    = word[7:0];
                merged_word = word;
            end
        endcase
        ext_word = {{24{sign_ext & sel_byte[7]}}, sel_byte};
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving the word-only dmem interface. One request is in
// flight at a time; byte stores are done as a read followed by a write.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_t  state;
    lsu_state_t  state_next;

    logic [31:0] lat_addr;
    logic        lat_byte;
    logic        lat_signed;
    logic        lat_we;
    logic        lat_err;
    logic [31:0] wbuf;
    logic [31:0] rdata_q;

    logic        accept;
    logic        req_bad;
    logic [31:0] lane_ext;
    logic [31:0] lane_merged;
    logic [31:0] load_value;

    assign accept     = req_valid && (state == ST_IDLE);
    assign req_bad    = addr_err(req_addr, req_byte, MEM_WORDS);
    assign load_value = lat_byte ? lane_ext : mem_rd;

    // wbuf holds the raw store data until RMW replaces it with the merged word,
    // so its low byte is the byte to insert during RMW.
    lsu_byte_lane u_byte_lane (
        .word        (mem_rd),
        .lane        (lat_addr[1:0]),
        .sign_ext    (lat_signed),
        .byte_in     (wbuf[7:0]),
        .ext_word    (lane_ext),
        .merged_word (lane_merged)
    );

    // State register plus the latched request, write buffer and load result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            lat_addr   <= 32'd0;
            lat_byte   <= 1'b0;
            lat_signed <= 1'b0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            wbuf       <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_addr   <= req_addr;
                lat_byte   <= req_byte;
                lat_signed <= req_signed;
                lat_we     <= req_we;
                lat_err    <= req_bad;
                wbuf       <= req_wdata;
            end
            if (state == ST_LOAD) begin
                rdata_q <= load_value;
            end
            if (state == ST_RMW) begin
                wbuf <= lane_merged;
            end
        end
    end

    // Next-state decode and all outputs from the current state and latched request.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = rdata_q;
        mem_a      = 32'd0;
        mem_we     = 1'b0;
        mem_wd     = 32'd0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (req_bad) begin
                        state_next = ST_RESP;
                    end else if (!req_we) begin
                        state_next = ST_LOAD;
                    end else if (req_byte) begin
                        state_next = ST_RMW;
                    end else begin
                        state_next = ST_WRITE;
                    end
                end
            end
            ST_LOAD: begin
                mem_a      = {lat_addr[31:2], 2'b00};
                state_next = ST_RESP;
            end
            ST_RMW: begin
                mem_a      = {lat_addr[31:2], 2'b00};
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                mem_a      = {lat_addr[31:2], 2'b00};
                mem_we     = 1'b1;
                mem_wd     = wbuf;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = lat_err;
                if (lat_we || lat_err) begin
                    resp_rdata = 32'd0;
                end
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed vector table, reset-abort and
// back-to-back sequences, then random requests against a word-array model.
module tb_dmem_lsu;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] bench_mem [0:63];
    logic [31:0] ref_mem   [0:63];
    int          we_count;
    logic [31:0] last_wd;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        we;
        logic        byt;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [0:15];

    dmem_lsu #(.MEM_WORDS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_byte   (req_byte),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory stand-in: combinational read, write on the rising edge.
    assign mem_rd = bench_mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            bench_mem[mem_a[7:2]] <= mem_wd;
            we_count              <= we_count + 1;
            last_wd               <= mem_wd;
        end
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour: plain arithmetic on a word array.
    task automatic model(input logic we, input logic byt, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output int wes, output logic [31:0] wd);
        int unsigned idx;
        int unsigned off;
        logic [31:0] w;
        logic [31:0] b;
        idx   = addr >> 2;
        off   = addr % 4;
        rdata = 32'd0;
        wd    = 32'd0;
        wes   = 0;
        err   = ((!byt) && (off != 0)) || (idx >= 64);
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            w   = ref_mem[idx];
            if (byt) begin
                b = (w >> (8 * off)) & 32'd255;
                if (sgn && b >= 128) rdata = b - 32'd256;
                else rdata = b;
            end else begin
                rdata = w;
            end
        end else begin
            wes = 1;
            if (byt) begin
                lat = 3;
                w   = (ref_mem[idx] & ~(32'hFF << (8 * off))) | ((wdata & 32'd255) << (8 * off));
            end else begin
                lat = 2;
                w   = wdata;
            end
            ref_mem[idx] = w;
            wd           = w;
        end
    endtask

    // Issue one request and measure the response and dmem write activity.
    task automatic applyStimulus(input logic we, input logic byt, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err,
                                 output int lat, output int wes, output logic [31:0] wd);
        int waited;
        int we0;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_byte   = byt;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        we0        = we_count;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_byte   = 1'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge clk);
        #1;
        checkOutput("resp_single_pulse", {31'd0, resp_valid}, 32'd0);
        wes = we_count - we0;
        wd  = last_wd;
    endtask

    // Compare one response against its expectation.
    task automatic compareResp(input string tag, input logic we,
                               input logic [31:0] addr,
                               input logic [31:0] rdata, input logic err, input int lat,
                               input int wes, input logic [31:0] wd,
                               input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                               input int e_wes, input logic [31:0] e_wd);
        checkOutput({tag, "_rdata"}, rdata, e_rdata);
        checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
        checkOutput({tag, "_latency"}, 32'(lat), 32'(e_lat));
        checkOutput({tag, "_we_pulses"}, 32'(wes), 32'(e_wes));
        if (we && !e_err) begin
            checkOutput({tag, "_mem_wd"}, wd, e_wd);
            checkOutput({tag, "_mem_word"}, bench_mem[addr[7:2]], e_wd);
        end
    endtask

    initial begin
        logic [31:0] g_rdata;
        logic        g_err;
        int          g_lat;
        int          g_wes;
        logic [31:0] g_wd;
        logic [31:0] m_rdata;
        logic        m_err;
        int          m_lat;
        int          m_wes;
        logic [31:0] m_wd;
        int          we0;
        int          k;
        int          pulses;
        logic        we_r;
        logic        byt_r;
        logic        sgn_r;
        logic [31:0] addr_r;
        logic [31:0] wdata_r;

        n_checks   = 0;
        n_fail     = 0;
        we_count   = 0;
        last_wd    = 32'd0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_byte   = 1'b0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;

        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom;
        end
        ref_mem[1]  = 32'h0000_8000;
        ref_mem[2]  = 32'hDEAD_BEEF;
        ref_mem[63] = 32'h7F00_0000;
        for (int i = 0; i < 64; i++) begin
            bench_mem[i] = ref_mem[i];
        end

        // Directed vectors: we, byte, signed, addr, wdata, rdata, err, latency, write data.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h0,          32'hDEAD_BEEF, 1'b0, 2, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0005, 32'h0,          32'hFFFF_FF80, 1'b0, 2, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0005, 32'h0,          32'h0000_0080, 1'b0, 2, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h1122_3344,  32'h0,         1'b0, 2, 32'h1122_3344};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0006, 32'h0000_00AB,  32'h0,         1'b0, 3, 32'h11AB_3344};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0,          32'h11AB_3344, 1'b0, 2, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0002, 32'h0,          32'h0,         1'b1, 1, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,          32'h0,         1'b1, 1, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h0000_00FF, 32'h0,          32'h0000_007F, 1'b0, 2, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0101, 32'h0000_0055,  32'h0,         1'b1, 1, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,          32'h0,         1'b1, 1, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h4000_0008, 32'h0,          32'h0,         1'b1, 1, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0000_0006, 32'h1234_5678,  32'h0,         1'b1, 1, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0000_000B, 32'h0,          32'h0000_00DE, 1'b0, 2, 32'h0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h0,          32'hFFFF_FFEF, 1'b0, 2, 32'h0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 32'h0000_00FC, 32'hFFFF_FF99,  32'h0,         1'b0, 3, 32'h7F00_0099};

        // Reset state.
        #3;
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_mem_a", mem_a, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_mem_wd", mem_wd, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] directed vectors");
        for (int i = 0; i < 16; i++) begin
            model(vecs[i].we, vecs[i].byt, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                  m_rdata, m_err, m_lat, m_wes, m_wd);
            applyStimulus(vecs[i].we, vecs[i].byt, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                          g_rdata, g_err, g_lat, g_wes, g_wd);
            compareResp($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr,
                        g_rdata, g_err, g_lat, g_wes, g_wd,
                        vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat,
                        (vecs[i].we && !vecs[i].exp_err) ? 1 : 0, vecs[i].exp_wd);
        end

        $display("[TB] reset during byte store read-modify-write");
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_byte   = 1'b1;
        req_signed = 1'b0;
        req_addr   = 32'h0000_0006;
        req_wdata  = 32'h0000_0055;
        we0        = we_count;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("abort_rmw_mem_we", {31'd0, mem_we}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_ready_in_reset", {31'd0, req_ready}, 32'd1);
        checkOutput("abort_mem_we_in_reset", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (resp_valid) pulses++;
        end
        checkOutput("abort_no_resp", 32'(pulses), 32'd0);
        checkOutput("abort_no_write", 32'(we_count - we0), 32'd0);
        checkOutput("abort_mem_unchanged", bench_mem[1], ref_mem[1]);
        checkOutput("abort_ready_after", {31'd0, req_ready}, 32'd1);

        $display("[TB] back-to-back store then load with valid held");
        model(1'b1, 1'b0, 1'b0, 32'h4, 32'hCAFE_F00D, m_rdata, m_err, m_lat, m_wes, m_wd);
        model(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, m_rdata, m_err, m_lat, m_wes, m_wd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_byte   = 1'b0;
        req_signed = 1'b0;
        req_addr   = 32'h0000_0004;
        req_wdata  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        req_we    = 1'b0;
        req_wdata = 32'h0BAD_0BAD;
        k = 1;
        while (!resp_valid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("b2b_store_latency", 32'(k), 32'd2);
        checkOutput("b2b_store_err", {31'd0, resp_err}, 32'd0);
        checkOutput("b2b_store_rdata", resp_rdata, 32'd0);
        k = 0;
        while (!req_ready && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        while (req_ready && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        req_valid = 1'b0;
        k = 1;
        while (!resp_valid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("b2b_load_latency", 32'(k), 32'd2);
        checkOutput("b2b_load_rdata", resp_rdata, m_rdata);
        checkOutput("b2b_load_err", {31'd0, resp_err}, 32'd0);
        checkOutput("b2b_mem_word", bench_mem[1], 32'hCAFE_F00D);

        $display("[TB] random requests");
        for (int n = 0; n < 300; n++) begin
            we_r    = 1'($urandom);
            byt_r   = 1'($urandom);
            sgn_r   = 1'($urandom);
            wdata_r = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                addr_r = $urandom;
            end else begin
                addr_r = 32'($urandom_range(0, 67) * 4 + $urandom_range(0, 3));
                if (!byt_r && $urandom_range(0, 3) != 0) addr_r[1:0] = 2'b00;
            end
            model(we_r, byt_r, sgn_r, addr_r, wdata_r, m_rdata, m_err, m_lat, m_wes, m_wd);
            applyStimulus(we_r, byt_r, sgn_r, addr_r, wdata_r, g_rdata, g_err, g_lat, g_wes, g_wd);
            compareResp($sformatf("rnd%0d", n), we_r, addr_r,
                        g_rdata, g_err, g_lat, g_wes, g_wd,
                        m_rdata, m_err, m_lat, m_wes, m_wd);
        end

        for (int i = 0; i < 64; i++) begin
            checkOutput($sformatf("final_mem%0d", i), bench_mem[i], ref_mem[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
